// File: rtl/pw_trig_sequencer.sv
// Control sequencer for the pulse-width trigger unit: holds shadow configuration, arms the unit,
// counts qualifying status edges and emits a one-cycle trigger followed by a holdoff interval.
module pw_trig_sequencer #(
    parameter int CW  = 32,
    parameter int EVW = 16
) (
    input  logic          cnt_clk,
    input  logic          cnt_clr,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    input  logic          arm,
    input  logic          abort,
    input  logic          pul_trig_status,
    output logic [CW-1:0] cmp_low,
    output logic [CW-1:0] cmp_high,
    output logic [1:0]    func_sel,
    output logic          pw_clr_n,
    output logic          trig_out,
    output logic          armed,
    output logic          busy,
    output logic          cfg_pending,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_ARMED   = 3'd3,
        S_HOLDOFF = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      settle_q, settle_d;
    logic [EVW-1:0]  ev_cnt_q, ev_cnt_d;
    logic [CW-1:0]   ho_q, ho_d;
    logic            trig_d;
    logic            trig_q, pw_clr_n_q, armed_q, busy_q;

    logic [CW-1:0]   sh_low_q, sh_high_q, sh_hold_q;
    logic [1:0]      sh_func_q;
    logic            sh_rearm_q;
    logic [EVW-1:0]  sh_evn_q;
    logic [CW-1:0]   act_low_q, act_high_q, act_hold_q;
    logic [1:0]      act_func_q;
    logic            act_rearm_q;
    logic [EVW-1:0]  act_evn_q;
    logic            dirty_q;

    logic            st_q, st_prev_q, rise;
    logic            cfg_hit;
    logic [EVW-1:0]  eff_n;
    logic [EVW:0]    ev_inc;

    assign cfg_hit = cfg_we && (cfg_addr <= 3'd4);

    // Shadow takes every write; active only follows shadow during LOAD, so the unit sees a
    // consistent configuration while it is held cleared.
    always_ff @(posedge cnt_clk or negedge cnt_clr) begin
        if (!cnt_clr) begin
            sh_low_q    <= '0;
            sh_high_q   <= '0;
            sh_hold_q   <= '0;
            sh_func_q   <= '0;
            sh_rearm_q  <= 1'b0;
            sh_evn_q    <= '0;
            act_low_q   <= '0;
            act_high_q  <= '0;
            act_hold_q  <= '0;
            act_func_q  <= '0;
            act_rearm_q <= 1'b0;
            act_evn_q   <= '0;
            dirty_q     <= 1'b0;
        end else begin
            if (state_q == S_LOAD) begin
                act_low_q   <= sh_low_q;
                act_high_q  <= sh_high_q;
                act_hold_q  <= sh_hold_q;
                act_func_q  <= sh_func_q;
                act_rearm_q <= sh_rearm_q;
                act_evn_q   <= sh_evn_q;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    3'd0:    sh_low_q  <= cfg_wdata;
                    3'd1:    sh_high_q <= cfg_wdata;
                    3'd2:    {sh_rearm_q, sh_func_q} <= cfg_wdata[2:0];
                    3'd3:    sh_hold_q <= cfg_wdata;
                    3'd4:    sh_evn_q  <= cfg_wdata[EVW-1:0];
                    default: ;
                endcase
            end
            if (cfg_hit)
                dirty_q <= 1'b1;
            else if (state_q == S_LOAD)
                dirty_q <= 1'b0;
        end
    end

    // Status is registered once before edge detection; the edge register tracks it continuously,
    // so a level already high when SETTLE ends never counts as a rise.
    assign rise   = st_q & ~st_prev_q;
    assign eff_n  = (act_evn_q == '0) ? EVW'(1) : act_evn_q;
    assign ev_inc = {1'b0, ev_cnt_q} + (EVW+1)'(1);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        ev_cnt_d = ev_cnt_q;
        ho_d     = ho_q;
        trig_d   = 1'b0;
        case (state_q)
            S_IDLE:    if (arm) state_d = dirty_q ? S_LOAD : S_SETTLE;
            S_LOAD:    state_d = S_SETTLE;
            S_SETTLE: begin
                if (settle_q == 2'd3) state_d = S_ARMED;
                else                  settle_d = settle_q + 2'd1;
            end
            S_ARMED: begin
                if (rise) begin
                    ev_cnt_d = ev_inc[EVW-1:0];
                    if (ev_inc >= {1'b0, eff_n}) begin
                        trig_d  = 1'b1;
                        state_d = S_HOLDOFF;
                    end
                end
            end
            S_HOLDOFF: begin
                if (ho_q >= act_hold_q) begin
                    if (act_rearm_q) state_d = dirty_q ? S_LOAD : S_SETTLE;
                    else             state_d = S_IDLE;
                end else begin
                    ho_d = ho_q + CW'(1);
                end
            end
            default:   state_d = S_IDLE;
        endcase
        if (state_d == S_SETTLE && state_q != S_SETTLE) begin
            settle_d = 2'd0;
            ev_cnt_d = '0;
        end
        // Counter starts at 1 so a zero holdoff still spends one cycle cleared.
        if (state_d == S_HOLDOFF && state_q != S_HOLDOFF) ho_d = CW'(1);
        if (abort) begin
            state_d  = S_IDLE;
            trig_d   = 1'b0;
            ev_cnt_d = '0;
        end
    end

    always_ff @(posedge cnt_clk or negedge cnt_clr) begin
        if (!cnt_clr) begin
            state_q    <= S_IDLE;
            settle_q   <= '0;
            ev_cnt_q   <= '0;
            ho_q       <= '0;
            st_q       <= 1'b0;
            st_prev_q  <= 1'b0;
            trig_q     <= 1'b0;
            pw_clr_n_q <= 1'b0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            ev_cnt_q   <= ev_cnt_d;
            ho_q       <= ho_d;
            st_q       <= pul_trig_status;
            st_prev_q  <= st_q;
            trig_q     <= trig_d;
            pw_clr_n_q <= (state_d == S_ARMED);
            armed_q    <= (state_d == S_ARMED);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign cmp_low     = act_low_q;
    assign cmp_high    = act_high_q;
    assign func_sel    = act_func_q;
    assign pw_clr_n    = pw_clr_n_q;
    assign trig_out    = trig_q;
    assign armed       = armed_q;
    assign busy        = busy_q;
    assign cfg_pending = dirty_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pw_trig_sequencer.sv
// Bench for pw_trig_sequencer: directed scenarios plus randomized episodes checked against a
// configuration model and trigger times derived from the event-count and holdoff rules.
module tb_pw_trig_sequencer;
  localparam int CW  = 32;
  localparam int EVW = 16;

  logic          cnt_clk = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_addr = '0;
  logic [CW-1:0] cfg_wdata = '0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          pul_trig_status = 1'b0;
  logic [CW-1:0] cmp_low, cmp_high;
  logic [1:0]    func_sel;
  logic          pw_clr_n, trig_out, armed, busy, cfg_pending;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_hi_q[$];
  logic [31:0] mon_e, mon_h;

  // configuration model: shadow, active, dirty
  logic [31:0] sh_low, sh_high, sh_hold, act_low, act_high, act_hold;
  logic [2:0]  sh_mode, act_mode;
  logic [15:0] sh_evn, act_evn;
  bit          dirty_m;

  bit          g_arm, g_we, g_load;
  logic [2:0]  g_addr;
  logic [31:0] g_data;

  pw_trig_sequencer #(.CW(CW), .EVW(EVW)) dut (
    .cnt_clk(cnt_clk), .cnt_clr(cnt_clr), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .arm(arm), .abort(abort), .pul_trig_status(pul_trig_status),
    .cmp_low(cmp_low), .cmp_high(cmp_high), .func_sel(func_sel), .pw_clr_n(pw_clr_n),
    .trig_out(trig_out), .armed(armed), .busy(busy), .cfg_pending(cfg_pending),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 cnt_clk = ~cnt_clk;
  always @(posedge cnt_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, actual, required);
    end
  endtask

  // monitor: every trigger pops the scoreboard
  always @(negedge cnt_clk) begin
    if (trig_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL trig_unexpected cyc=%0d actual=1 required=0", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_h = exp_hi_q.pop_front();
        chk("trig_cycle", cyc, mon_e);
        chk("trig_cmp_high", cmp_high, mon_h);
      end
    end
  end

  task automatic model_reset();
    sh_low = 0; sh_high = 0; sh_hold = 0; sh_mode = 0; sh_evn = 0;
    act_low = 0; act_high = 0; act_hold = 0; act_mode = 0; act_evn = 0;
    dirty_m = 0;
  endtask

  function automatic logic [31:0] rand_data(input logic [2:0] a);
    case (a)
      3'd2:    return 32'($urandom_range(0, 7));
      3'd3:    return 32'($urandom_range(0, 6));
      3'd4:    return 32'($urandom_range(0, 4));
      default: return $urandom;
    endcase
  endfunction

  // driver: one cycle with the given inputs, checks at the falling edge, model advance after
  task automatic cycle_chk(input bit st, input bit ab, input bit e_armed, input bit e_busy);
    pul_trig_status = st;
    abort = ab;
    arm = g_arm;
    cfg_we = g_we;
    cfg_addr = g_addr;
    cfg_wdata = g_data;
    @(negedge cnt_clk);
    chk("armed", armed, e_armed);
    chk("pw_clr_n", pw_clr_n, e_armed);
    chk("busy", busy, e_busy);
    chk("cmp_low", cmp_low, act_low);
    chk("cmp_high", cmp_high, act_high);
    chk("func_sel", func_sel, act_mode[1:0]);
    chk("cfg_pending", cfg_pending, dirty_m);
    if (!e_busy) chk("dbg_state_idle", dbg_state, 0);
    @(posedge cnt_clk);
    #1;
    if (g_load) begin
      act_low = sh_low; act_high = sh_high; act_hold = sh_hold;
      act_mode = sh_mode; act_evn = sh_evn; dirty_m = 0;
    end
    if (g_we) begin
      case (g_addr)
        3'd0: sh_low = g_data;
        3'd1: sh_high = g_data;
        3'd2: sh_mode = g_data[2:0];
        3'd3: sh_hold = g_data;
        3'd4: sh_evn = g_data[15:0];
        default: ;
      endcase
      dirty_m = 1;
    end
    g_arm = 0; g_we = 0; g_load = 0;
    arm = 0; cfg_we = 0; abort = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle_chk(0, 0, 0, 0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    g_we = 1; g_addr = a; g_data = d;
    cycle_chk(0, 0, 0, 0);
  endtask

  // cycles between leaving IDLE/HOLDOFF and ARMED: LOAD (if dirty) plus four SETTLE cycles
  task automatic pre(input bit d);
    for (int i = 0; i < (d ? 5 : 4); i++) begin
      if (d && i == 0) g_load = 1;
      cycle_chk(0, 0, 0, 1);
    end
  endtask

  task automatic start_episode();
    bit d;
    d = dirty_m;
    g_arm = 1;
    cycle_chk(0, 0, 0, 0);
    pre(d);
  endtask

  task automatic do_reset_check();
    cnt_clr = 1'b0;
    pul_trig_status = 1'b0;
    #1;
    chk("rst_pw_clr_n", pw_clr_n, 0);
    chk("rst_trig_out", trig_out, 0);
    chk("rst_armed", armed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_pending", cfg_pending, 0);
    chk("rst_cmp_low", cmp_low, 0);
    chk("rst_cmp_high", cmp_high, 0);
    chk("rst_func_sel", func_sel, 0);
    model_reset();
    @(posedge cnt_clk);
    #1;
    cnt_clr = 1'b1;
  endtask

  // Entered on the first ARMED cycle. abort_mode: 0 none, 1 abort with the qualifying rise
  // detection, 2 abort on the first ARMED cycle.
  task automatic trigger_phase(input int abort_mode, input bit hw_en, input logic [2:0] hw_addr,
                               input logic [31:0] hw_data, input bit rst_hold,
                               output bit ended_idle, output bit next_dirty);
    int effn, m, gap, w;
    bit rearm;
    effn = (act_evn == 0) ? 1 : int'(act_evn);
    m = (act_hold == 0) ? 1 : int'(act_hold);
    rearm = act_mode[2];
    ended_idle = 1;
    next_dirty = 0;
    if (abort_mode == 2) begin
      cycle_chk(0, 1, 1, 1);
      return;
    end
    for (int k = 1; k <= effn; k++) begin
      gap = $urandom_range(1, 4);
      repeat (gap) cycle_chk(0, 0, 1, 1);
      w = $urandom_range(1, 3);
      if (k < effn) begin
        repeat (w) cycle_chk(1, 0, 1, 1);
      end else begin
        if (abort_mode != 1) begin
          exp_q.push_back(32'(cyc + 2));
          exp_hi_q.push_back(act_high);
        end
        cycle_chk(1, 0, 1, 1);
        cycle_chk(w >= 2, abort_mode == 1, 1, 1);
        if (abort_mode == 1) return;
        for (int i = 0; i < m; i++) begin
          if (rst_hold && i == 1) begin
            do_reset_check();
            return;
          end
          if (hw_en && i == 0) begin
            g_we = 1; g_addr = hw_addr; g_data = hw_data;
          end
          if (i == m - 1) next_dirty = dirty_m;
          cycle_chk(w >= i + 3, 0, 0, 1);
        end
        ended_idle = !rearm;
      end
    end
  endtask

  initial begin
    bit ended, nd;
    int nw, am;
    logic [2:0] a;
    model_reset();
    g_arm = 0; g_we = 0; g_load = 0; g_addr = 0; g_data = 0;

    // reset values
    repeat (2) @(posedge cnt_clk);
    @(negedge cnt_clk);
    chk("reset_pw_clr_n", pw_clr_n, 0);
    chk("reset_trig_out", trig_out, 0);
    chk("reset_armed", armed, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cfg_pending", cfg_pending, 0);
    chk("reset_cmp_low", cmp_low, 0);
    chk("reset_cmp_high", cmp_high, 0);
    chk("reset_func_sel", func_sel, 0);
    chk("reset_state", dbg_state, 0);
    @(posedge cnt_clk);
    #1;
    cnt_clr = 1'b1;
    idle(2);

    // config/load then single trigger with holdoff 10
    wr(0, 100); wr(1, 200); wr(2, 3'b010);
    idle(3);
    wr(3, 10); wr(4, 1);
    start_episode();
    trigger_phase(0, 0, 0, 0, 0, ended, nd);
    idle(2);

    // Nth event, then event_n = 0 behaving as 1
    wr(4, 3);
    start_episode();
    trigger_phase(0, 0, 0, 0, 0, ended, nd);
    idle(1);
    wr(4, 0);
    start_episode();
    trigger_phase(0, 0, 0, 0, 0, ended, nd);
    idle(1);

    // auto re-arm with a write landing during holdoff
    wr(2, 3'b110); wr(3, 3); wr(4, 1);
    start_episode();
    trigger_phase(0, 1, 3'd1, 50, 0, ended, nd);
    chk("rearm_not_idle", ended, 0);
    chk("rearm_dirty", nd, 1);
    pre(nd);
    trigger_phase(0, 0, 0, 0, 0, ended, nd);
    pre(nd);
    trigger_phase(2, 0, 0, 0, 0, ended, nd);
    idle(2);

    // abort colliding with the qualifying rise, then a normal episode
    wr(2, 3'b010);
    start_episode();
    trigger_phase(1, 0, 0, 0, 0, ended, nd);
    idle(2);
    start_episode();
    trigger_phase(0, 0, 0, 0, 0, ended, nd);
    idle(1);

    // reset during holdoff
    wr(3, 10);
    start_episode();
    trigger_phase(0, 0, 0, 0, 1, ended, nd);
    idle(2);

    // randomized episodes
    for (int it = 0; it < 12; it++) begin
      nw = $urandom_range(1, 3);
      repeat (nw) begin
        a = 3'($urandom_range(0, 4));
        wr(a, rand_data(a));
      end
      if ($urandom_range(0, 1) == 1) idle(1);
      start_episode();
      for (int p = 0; p < 4; p++) begin
        am = (p >= 2) ? 2 : (($urandom_range(0, 4) == 0) ? 1 : 0);
        a = 3'($urandom_range(0, 4));
        trigger_phase(am, $urandom_range(0, 1) == 1, a, rand_data(a), 0, ended, nd);
        if (ended) break;
        pre(nd);
      end
      idle(1);
    end

    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
